// File: rtl/strobe_meter_pkg.sv
// Shared definitions for the strobe period meter: FSM state encoding and
// the saturation constant used by WIDTH-bit tick counters.
package strobe_meter_pkg;

  // IDLE: no strobe seen since reset; MEASURE: counting ticks between strobes.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_e;

  // All-ones value of a counter of the given width, i.e. 2^width - 1.
  function automatic logic [31:0] sat_max(input int unsigned width);
    if (width >= 32) begin
      return '1;
    end
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_incr.sv
// WIDTH-bit saturating incrementer. When inc_i is high and value_i is
// already all-ones, next_o stays all-ones and sat_o flags the lost tick.
// Purely combinational so any counter can wrap its own register around it.
module sat_incr
  import strobe_meter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] next_o,
  output logic             sat_o
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(sat_max(WIDTH));

  // Increment unless the counter is already pinned at the top.
  always_comb begin
    sat_o  = inc_i && (value_i == MaxVal);
    next_o = value_i;
    if (inc_i && !sat_o) begin
      next_o = value_i + WIDTH'(1);
    end
  end

endmodule

// File: rtl/strobe_period_meter.sv
// Strobe period meter: counts qualified enable ticks between consecutive
// strobes and hands each measurement to a one-entry holding register.
//
// Output handshake: a result is offered while out_valid is high and is
// transferred in any cycle where out_valid && out_ready. period and
// period_ovf never change while out_valid is high and out_ready is low.
// A new result arriving while the register is full and not draining is
// discarded and reported by a one-cycle dropped pulse. All outputs are
// registered, so there is no combinational input-to-output path.
module strobe_period_meter
  import strobe_meter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             strobe_in,
  input  logic             out_ready,
  output logic [WIDTH-1:0] period,
  output logic             period_ovf,
  output logic             out_valid,
  output logic             dropped,
  output logic             state_dbg
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             pov_q, pov_d;
  logic             valid_q, valid_d;
  logic             dropped_q, dropped_d;

  logic [WIDTH-1:0] inc_next;
  logic             inc_sat;
  logic             res_valid;
  logic             xfer;
  logic             load;

  sat_incr #(
    .WIDTH(WIDTH)
  ) u_sat_incr (
    .value_i(cnt_q),
    .inc_i  (enable),
    .next_o (inc_next),
    .sat_o  (inc_sat)
  );

  // Next-state and counter logic: the first strobe only arms the meter;
  // later strobes emit {cnt, ovf} and restart counting, with the strobe
  // cycle's own enable belonging to the new period.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    res_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (strobe_in) begin
          state_d = ST_MEASURE;
          cnt_d   = WIDTH'(enable);
        end else begin
          cnt_d = '0;
        end
      end
      ST_MEASURE: begin
        if (strobe_in) begin
          res_valid = 1'b1;
          cnt_d     = WIDTH'(enable);
          ovf_d     = 1'b0;
        end else begin
          cnt_d = inc_next;
          ovf_d = ovf_q | inc_sat;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding register: load when empty or draining this cycle, otherwise
  // drop the new result; valid falls only on a transfer without a load.
  always_comb begin
    xfer      = valid_q && out_ready;
    load      = res_valid && (!valid_q || xfer);
    period_d  = period_q;
    pov_d     = pov_q;
    valid_d   = valid_q;
    dropped_d = res_valid && !load;
    if (load) begin
      period_d = cnt_q;
      pov_d    = ovf_q;
      valid_d  = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  // State, counter and output registers; reset clears everything,
  // including a partial count and any held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      period_q  <= '0;
      pov_q     <= 1'b0;
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      period_q  <= period_d;
      pov_q     <= pov_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
    end
  end

  assign period     = period_q;
  assign period_ovf = pov_q;
  assign out_valid  = valid_q;
  assign dropped    = dropped_q;
  assign state_dbg  = state_q;

endmodule

// File: doc/strobe_period_meter.md
# strobe_period_meter

Receive-side counterpart of the team's strobe counter. It observes a strobe stream and measures the number of qualified `enable` ticks between consecutive strobes, so a counter loaded with value N reads back as N. Each completed measurement is delivered through a one-entry valid/ready holding register, with overflow and dropped-result flags. It sits downstream of strobe generators for period checking, rate recovery and self-test.

## Interface
- WIDTH, 4, width of the tick counter and of the reported period.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  tick qualifier; one count per cycle it is high.
- strobe_in  in  1  strobe being measured; each high cycle is one event.
- period  out  WIDTH  measured tick count; stable while `out_valid` is high.
- period_ovf  out  1  the held result saturated at 2^WIDTH-1; qualified by `out_valid`.
- out_valid  out  1  a result is held.
- out_ready  in  1  consumer accepts; transfer when `out_valid && out_ready`.
- dropped  out  1  one-cycle pulse: a new result was discarded because the holding register was full.

## Operation
- States: IDLE (no strobe seen since reset) and MEASURE.
- IDLE:
  - `strobe_in` high -> go to MEASURE; `cnt <= enable`. No result is produced, because the first strobe only arms the meter.
  - `strobe_in` low -> `cnt` held at 0.
- MEASURE, `strobe_in` low: `cnt <= sat(cnt + enable)`. If the increment would exceed 2^WIDTH-1, `cnt` stays at all-ones and the internal `ovf` flag is set.
- MEASURE, `strobe_in` high: the result is {`cnt`, `ovf`}. Then `cnt <= enable` and `ovf <= 0`.
  - An `enable` in the same cycle as a strobe counts toward the next period.
  - Consequence: enables in cycles [previous strobe, current strobe - 1] are counted.
- Result hand-off:
  - Holding register empty, or emptied this cycle by a transfer: load the result and set `out_valid = 1`.
  - Holding register full and not transferring: keep the old result, discard the new one, pulse `dropped`.
- Back-to-back strobes with no enable between them report period 0, and that result is valid.
- `out_valid` falls only on a transfer with no simultaneous load.

## Timing
- Reset values: `period = 0`, `period_ovf = 0`, `out_valid = 0`, `dropped = 0`, state IDLE, `cnt = 0`, `ovf = 0`.
- Reset has priority over every input. Reset mid-measurement discards the partial count and any held result.
- Latency: a strobe in cycle t gives `out_valid` high in cycle t+1, provided the register is free at t.
- Transfer and load in the same cycle keep `out_valid` high with the new `period` at t+1. This sustains one result per strobe with `out_ready` tied high.
- `dropped` is registered and is high in cycle t+1 only.
- `period` and `period_ovf` do not change while `out_valid && !out_ready`.
- Throughput: a strobe on every cycle is supported.
- No combinational path from any input to any output.

## Structure
- Package `strobe_meter_pkg`:
  - state encoding localparams ST_IDLE = 1'b0, ST_MEASURE = 1'b1;
  - the all-ones saturation constant as a function of WIDTH.
- Sub-module `sat_incr`:
  - WIDTH-bit saturating incrementer;
  - inputs value and inc, outputs next value and sat;
  - purely combinational, reusable by other counters.
- Top module: state register, `cnt`/`ovf` registers, holding register and flag logic.
- Expected size: about 150-250 lines including both modules.

## Test plan
- Arming and period readback:
  - WIDTH=4, `out_ready = 1`, enable every other cycle, strobes 5 enable-ticks apart (driven by a counter with reset_value 5);
  - required: first strobe gives no result, then `period = 5` on every following strobe, `out_valid` pulses one cycle per strobe, `period_ovf = 0`.
- Saturation:
  - enable always high, strobes 20 cycles apart, WIDTH=4;
  - required: `period = 15`, `period_ovf = 1`; the next period of 3 reports `period = 3`, `period_ovf = 0`.
- Back-pressure:
  - `out_ready = 0` across two measurements, 4 then 6;
  - required: `period` holds 4, `dropped` pulses once at the second strobe+1;
  - then one `out_ready` cycle drains 4 and `out_valid` falls.
- Simultaneous events:
  - strobe and enable in the same cycle, plus a transfer coinciding with a new load;
  - required: that enable is counted in the next period (e.g. 1 + 2 further ticks = 3);
  - required: `out_valid` stays high and `period` updates with no gap.
- Zero period: strobes on consecutive cycles with `enable = 0` -> `period = 0`, `out_valid = 1`.
- Reset mid-operation:
  - `rst` asserted while `cnt = 7` and a result is held;
  - required: all outputs 0 next cycle, state IDLE, the next strobe only arms.
